// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 on a 25 MHz pixel clock.
// Every output is registered and decoded from the next counter values, so all outputs line up with hpos/vpos.
module vga_timing_gen #(
    parameter int   H_VIS       = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VIS       = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   STRIP_LINES = 32
) (
    input  logic       clk25M,
    input  logic       reset,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic       line_tick,
    output logic       frame_tick,
    output logic       bank_sel,
    output logic [3:0] strip_idx,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int STRIP_SHIFT = $clog2(STRIP_LINES);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_W    = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W    = 10'(V_VIS);
    localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] STRIP_MASK = 10'(STRIP_LINES - 1);

    logic [9:0] hpos_reg, hpos_next;
    logic [9:0] vpos_reg, vpos_next;
    logic       hsync_reg, hsync_next;
    logic       vsync_reg, vsync_next;
    logic       display_en_reg, display_en_next;
    logic       line_tick_reg, line_tick_next;
    logic       frame_tick_reg, frame_tick_next;
    logic       bank_sel_reg, bank_sel_next;
    logic [3:0] strip_idx_reg, strip_idx_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic       line_start;
    logic       vis_line;
    logic       strip_boundary;

    always_comb begin
        hpos_next = hpos_reg + 10'd1;
        vpos_next = vpos_reg;
        if (hpos_reg == H_LAST) begin
            hpos_next = '0;
            if (vpos_reg == V_LAST) begin
                vpos_next = '0;
            end else begin
                vpos_next = vpos_reg + 10'd1;
            end
        end

        // hpos only reaches 0 via a wrap, so the reset-held position never raises a tick
        line_start      = (hpos_next == '0);
        vis_line        = (vpos_next < V_VIS_W);
        display_en_next = (hpos_next < H_VIS_W) && vis_line;
        hsync_next      = (hpos_next >= HS_START && hpos_next <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_next      = (vpos_next >= VS_START && vpos_next <= VS_END) ? SYNC_POL : ~SYNC_POL;
        line_tick_next  = line_start;
        frame_tick_next = line_start && (vpos_next == V_VIS_W);

        // Bank flips at the top of every strip after the first, including the one at vblank start;
        // the frame wrap always restores bank 0 regardless of parity.
        strip_boundary = line_start && (vpos_next != '0) && ((vpos_next & STRIP_MASK) == '0)
                         && (vpos_next <= V_VIS_W);
        if (line_start && vpos_next == '0) begin
            bank_sel_next = 1'b0;
        end else begin
            bank_sel_next = bank_sel_reg ^ strip_boundary;
        end

        strip_idx_next = vis_line ? 4'(vpos_next >> STRIP_SHIFT) : 4'd0;
        frame_cnt_next = frame_cnt_reg + {7'd0, frame_tick_next};
    end

    always_ff @(posedge clk25M) begin
        if (reset) begin
            hpos_reg       <= '0;
            vpos_reg       <= '0;
            hsync_reg      <= ~SYNC_POL;
            vsync_reg      <= ~SYNC_POL;
            display_en_reg <= 1'b0;
            line_tick_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
            bank_sel_reg   <= 1'b0;
            strip_idx_reg  <= '0;
            frame_cnt_reg  <= '0;
        end else begin
            hpos_reg       <= hpos_next;
            vpos_reg       <= vpos_next;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
            display_en_reg <= display_en_next;
            line_tick_reg  <= line_tick_next;
            frame_tick_reg <= frame_tick_next;
            bank_sel_reg   <= bank_sel_next;
            strip_idx_reg  <= strip_idx_next;
            frame_cnt_reg  <= frame_cnt_next;
        end
    end

    assign hpos       = hpos_reg;
    assign vpos       = vpos_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign display_en = display_en_reg;
    assign line_tick  = line_tick_reg;
    assign frame_tick = frame_tick_reg;
    assign bank_sel   = bank_sel_reg;
    assign strip_idx  = strip_idx_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance for reset/line timing, plus a shrunken active-high-sync
// instance (6x34 raster, 2-line strips, 15 strips) for frame, bank, mid-frame reset and frame_cnt wrap.
module tb_vga_timing_gen;

    logic clk25M = 1'b0;
    always #20 clk25M = ~clk25M;

    logic rst_full, rst_small;

    logic [9:0] f_hpos, f_vpos;
    logic       f_hsync, f_vsync, f_display_en, f_line_tick, f_frame_tick, f_bank_sel;
    logic [3:0] f_strip_idx;
    logic [7:0] f_frame_cnt;

    logic [9:0] s_hpos, s_vpos;
    logic       s_hsync, s_vsync, s_display_en, s_line_tick, s_frame_tick, s_bank_sel;
    logic [3:0] s_strip_idx;
    logic [7:0] s_frame_cnt;

    int checks = 0;
    int errors = 0;

    vga_timing_gen u_full (
        .clk25M(clk25M), .reset(rst_full),
        .hpos(f_hpos), .vpos(f_vpos), .hsync(f_hsync), .vsync(f_vsync),
        .display_en(f_display_en), .line_tick(f_line_tick), .frame_tick(f_frame_tick),
        .bank_sel(f_bank_sel), .strip_idx(f_strip_idx), .frame_cnt(f_frame_cnt)
    );

    // h: vis 2, sync at 3..4, total 6; v: vis 30, sync lines 31..32, total 34; frame 204 cycles
    vga_timing_gen #(
        .H_VIS(2), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(30), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .STRIP_LINES(2)
    ) u_small (
        .clk25M(clk25M), .reset(rst_small),
        .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
        .display_en(s_display_en), .line_tick(s_line_tick), .frame_tick(s_frame_tick),
        .bank_sel(s_bank_sel), .strip_idx(s_strip_idx), .frame_cnt(s_frame_cnt)
    );

    task automatic step();
        @(posedge clk25M);
        @(negedge clk25M);
    endtask

    task automatic test_reset();
        rst_full  = 1'b1;
        rst_small = 1'b1;
        repeat (5) step();
        checks++; if (f_hpos !== 10'd0) begin errors++; $display("FAIL reset_hpos got %0d want 0", f_hpos); end
        checks++; if (f_vpos !== 10'd0) begin errors++; $display("FAIL reset_vpos got %0d want 0", f_vpos); end
        checks++; if (f_display_en !== 1'b0) begin errors++; $display("FAIL reset_de got %b want 0", f_display_en); end
        checks++; if (f_hsync !== 1'b1 || f_vsync !== 1'b1) begin errors++; $display("FAIL reset_sync got h=%b v=%b want 1/1", f_hsync, f_vsync); end
        checks++; if (f_line_tick !== 1'b0 || f_frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ticks got l=%b f=%b want 0/0", f_line_tick, f_frame_tick); end
        checks++; if (f_bank_sel !== 1'b0 || f_strip_idx !== 4'd0 || f_frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_bank got bank=%b strip=%0d fc=%0d want 0/0/0", f_bank_sel, f_strip_idx, f_frame_cnt); end
        checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL reset_sync_pol1 got h=%b v=%b want 0/0", s_hsync, s_vsync); end
        rst_full = 1'b0;
        step();
        checks++; if (f_hpos !== 10'd1 || f_vpos !== 10'd0) begin errors++; $display("FAIL release_pos got (%0d,%0d) want (1,0)", f_hpos, f_vpos); end
        checks++; if (f_display_en !== 1'b1) begin errors++; $display("FAIL release_de got %b want 1", f_display_en); end
        checks++; if (f_line_tick !== 1'b0) begin errors++; $display("FAIL release_line_tick got %b want 0", f_line_tick); end
        $display("reset: full instance released at (%0d,%0d)", f_hpos, f_vpos);
    endtask

    // Walks 1600 cycles from (1,0) through two full lines on the 640x480 instance.
    task automatic test_line();
        int eh = 1, ev = 0, hs_total = 0, de_total = 0, lt_total = 0;
        logic exp_hs, exp_de, exp_lt;
        for (int n = 0; n < 1600; n++) begin
            exp_hs = !(eh >= 656 && eh <= 751);
            exp_de = (eh < 640);
            exp_lt = (eh == 0);
            checks++; if (f_hpos !== 10'(eh) || f_vpos !== 10'(ev)) begin errors++; $display("FAIL line_pos got (%0d,%0d) want (%0d,%0d)", f_hpos, f_vpos, eh, ev); end
            checks++; if (f_hsync !== exp_hs) begin errors++; $display("FAIL line_hsync at h=%0d got %b want %b", eh, f_hsync, exp_hs); end
            checks++; if (f_display_en !== exp_de) begin errors++; $display("FAIL line_de at h=%0d got %b want %b", eh, f_display_en, exp_de); end
            checks++; if (f_line_tick !== exp_lt) begin errors++; $display("FAIL line_tick at h=%0d got %b want %b", eh, f_line_tick, exp_lt); end
            checks++; if (f_vsync !== 1'b1 || f_frame_tick !== 1'b0 || f_bank_sel !== 1'b0 || f_strip_idx !== 4'd0) begin errors++; $display("FAIL line_static got vs=%b ft=%b bank=%b strip=%0d want 1/0/0/0", f_vsync, f_frame_tick, f_bank_sel, f_strip_idx); end
            if (f_hsync === 1'b0) hs_total++;
            if (f_display_en === 1'b1) de_total++;
            if (f_line_tick === 1'b1) lt_total++;
            step();
            if (eh == 799) begin eh = 0; ev++; end else eh++;
        end
        checks++; if (hs_total != 192) begin errors++; $display("FAIL line_hsync_count got %0d want 192", hs_total); end
        checks++; if (de_total != 1280) begin errors++; $display("FAIL line_de_count got %0d want 1280", de_total); end
        checks++; if (lt_total != 2) begin errors++; $display("FAIL line_tick_count got %0d want 2", lt_total); end
        $display("line: hsync cycles=%0d de cycles=%0d line_ticks=%0d", hs_total, de_total, lt_total);
    endtask

    // Two frames on the small instance with a cycle-exact expectation of every output.
    task automatic test_frames();
        int eh = 1, ev = 0, efc = 0, ticks = 0, last_tick = 0;
        logic exp_vs, exp_hs, exp_de, exp_ft, exp_bank;
        logic [3:0] exp_strip;
        rst_small = 1'b1;
        step();
        rst_small = 1'b0;
        step();
        for (int n = 0; n < 3 * 204; n++) begin
            exp_vs    = (ev == 31 || ev == 32);
            exp_hs    = (eh == 3 || eh == 4);
            exp_de    = (eh < 2 && ev < 30);
            exp_ft    = (eh == 0 && ev == 30);
            exp_strip = (ev < 30) ? 4'(ev / 2) : 4'd0;
            exp_bank  = (ev < 30) ? 1'((ev / 2) % 2) : 1'b1;
            if (exp_ft) efc++;
            checks++; if (s_hpos !== 10'(eh) || s_vpos !== 10'(ev)) begin errors++; $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", s_hpos, s_vpos, eh, ev); end
            checks++; if (s_vsync !== exp_vs || s_hsync !== exp_hs) begin errors++; $display("FAIL frame_sync at (%0d,%0d) got h=%b v=%b want h=%b v=%b", eh, ev, s_hsync, s_vsync, exp_hs, exp_vs); end
            checks++; if (s_display_en !== exp_de || s_frame_tick !== exp_ft) begin errors++; $display("FAIL frame_de_tick at (%0d,%0d) got de=%b ft=%b want de=%b ft=%b", eh, ev, s_display_en, s_frame_tick, exp_de, exp_ft); end
            checks++; if (s_strip_idx !== exp_strip || s_bank_sel !== exp_bank) begin errors++; $display("FAIL frame_bank at v=%0d got strip=%0d bank=%b want strip=%0d bank=%b", ev, s_strip_idx, s_bank_sel, exp_strip, exp_bank); end
            checks++; if (s_frame_cnt !== 8'(efc)) begin errors++; $display("FAIL frame_cnt at (%0d,%0d) got %0d want %0d", eh, ev, s_frame_cnt, efc); end
            if (s_frame_tick === 1'b1) begin
                ticks++;
                if (ticks == 2) begin
                    checks++; if (n - last_tick != 204) begin errors++; $display("FAIL frame_spacing got %0d want 204", n - last_tick); end
                    break;
                end
                last_tick = n;
            end
            step();
            if (eh == 5) begin eh = 0; ev = (ev == 33) ? 0 : ev + 1; end else eh++;
        end
        checks++; if (ticks != 2) begin errors++; $display("FAIL frame_tick_count got %0d want 2", ticks); end
        $display("frames: frame_ticks=%0d frame_cnt=%0d", ticks, s_frame_cnt);
    endtask

    // Pulses reset at (3,20) mid-frame and checks the restart has no stale tick or early bank flip.
    task automatic test_mid_reset();
        int n = 0, steps = 0;
        while (!(s_hpos == 10'd3 && s_vpos == 10'd20) && n < 300) begin
            step();
            n++;
        end
        checks++; if (n >= 300) begin errors++; $display("FAIL midreset_reach got (%0d,%0d) want (3,20)", s_hpos, s_vpos); end
        rst_small = 1'b1;
        step();
        checks++; if (s_hpos !== 10'd0 || s_vpos !== 10'd0) begin errors++; $display("FAIL midreset_pos got (%0d,%0d) want (0,0)", s_hpos, s_vpos); end
        checks++; if (s_display_en !== 1'b0 || s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL midreset_outs got de=%b h=%b v=%b want 0/0/0", s_display_en, s_hsync, s_vsync); end
        checks++; if (s_bank_sel !== 1'b0 || s_strip_idx !== 4'd0 || s_frame_cnt !== 8'd0) begin errors++; $display("FAIL midreset_state got bank=%b strip=%0d fc=%0d want 0/0/0", s_bank_sel, s_strip_idx, s_frame_cnt); end
        rst_small = 1'b0;
        step();
        checks++; if (s_hpos !== 10'd1 || s_line_tick !== 1'b0 || s_frame_tick !== 1'b0) begin errors++; $display("FAIL midreset_release got h=%0d lt=%b ft=%b want 1/0/0", s_hpos, s_line_tick, s_frame_tick); end
        while (s_frame_tick !== 1'b1 && steps < 400) begin
            if (s_bank_sel === 1'b1 && s_vpos < 10'd2) begin
                checks++; errors++; $display("FAIL midreset_early_bank got bank=1 at v=%0d want 0", s_vpos);
            end
            step();
            steps++;
        end
        checks++; if (steps != 179) begin errors++; $display("FAIL midreset_tick_delay got %0d want 179", steps); end
        checks++; if (s_hpos !== 10'd0 || s_vpos !== 10'd30 || s_frame_cnt !== 8'd1) begin errors++; $display("FAIL midreset_tick_pos got (%0d,%0d) fc=%0d want (0,30) fc=1", s_hpos, s_vpos, s_frame_cnt); end
        $display("mid_reset: first frame_tick %0d cycles after release", steps + 1);
    endtask

    task automatic test_frame_wrap();
        int ticks = 0, n = 0;
        logic [7:0] exp_fc;
        rst_small = 1'b1;
        step();
        rst_small = 1'b0;
        while (ticks < 256 && n < 256 * 204 + 400) begin
            step();
            n++;
            if (s_frame_tick === 1'b1) begin
                ticks++;
                exp_fc = ticks[7:0];
                checks++; if (s_frame_cnt !== exp_fc) begin errors++; $display("FAIL wrap_cnt tick %0d got %0d want %0d", ticks, s_frame_cnt, exp_fc); end
            end
        end
        checks++; if (ticks != 256) begin errors++; $display("FAIL wrap_ticks got %0d want 256", ticks); end
        checks++; if (s_frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", s_frame_cnt); end
        $display("frame_wrap: %0d frame_ticks, frame_cnt=%0d", ticks, s_frame_cnt);
    endtask

    initial begin
        rst_full  = 1'b1;
        rst_small = 1'b1;
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
